// File: rtl/uart_rx_cmd.sv
// 8N1 serial receiver for the robot debug UART link, followed by a
// single-character ASCII command decoder driving direction/drive/override.
module uart_rx_cmd #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 9600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxData,
  output logic [7:0] rxByte,
  output logic       rxValid,
  output logic       frameErr,
  output logic [1:0] cmdDir,
  output logic       cmdDrive,
  output logic       cmdOverride,
  output logic       cmdValid,
  output logic       cmdErr
);

  // Direction and drive codes shared with the drive logic
  localparam logic [1:0] DC_STOP       = 2'd0;
  localparam logic [1:0] DC_PROCEED    = 2'd1;
  localparam logic [1:0] DC_TURN_LEFT  = 2'd2;
  localparam logic [1:0] DC_TURN_RIGHT = 2'd3;
  localparam logic       FORWARDS      = 1'b0;
  localparam logic       REVERSE       = 1'b1;

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

  state_t           state, state_nx;
  logic             rx_meta, rx_s;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift_reg;
  logic             cnt_clr, shift_en, byte_ok, frame_bad;

  // Fold lower-case letters onto upper case; everything else passes through
  function automatic logic [7:0] fold_case(input logic [7:0] b);
    if (b >= 8'h61 && b <= 8'h7A) fold_case = b & 8'hDF;
    else                          fold_case = b;
  endfunction

  // Two-flop synchronizer; resets to the idle (high) line level
  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rxData;
      rx_s    <= rx_meta;
    end
  end

  // Receive FSM state register
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  // Receive FSM next state and per-cycle control strobes
  always_comb begin
    state_nx  = state;
    cnt_clr   = 1'b0;
    shift_en  = 1'b0;
    byte_ok   = 1'b0;
    frame_bad = 1'b0;
    case (state)
      IDLE: begin
        if (!rx_s) begin
          state_nx = START;
          cnt_clr  = 1'b1;
        end
      end
      START: begin
        // Mid start bit: a high line here means the falling edge was a glitch
        if (cnt == HALF_LAST) begin
          cnt_clr  = 1'b1;
          state_nx = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt == FULL_LAST) begin
          cnt_clr  = 1'b1;
          shift_en = 1'b1;
          if (bit_idx == 3'd7) state_nx = STOP;
        end
      end
      STOP: begin
        if (cnt == FULL_LAST) begin
          cnt_clr = 1'b1;
          if (rx_s) begin
            byte_ok  = 1'b1;
            state_nx = IDLE;
          end else begin
            frame_bad = 1'b1;
            state_nx  = BREAK;
          end
        end
      end
      BREAK: begin
        // Hold off until the line returns high so a stuck-low line is not a frame
        if (rx_s) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Bit-time counter and data bit index
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt     <= '0;
      bit_idx <= 3'd0;
    end else begin
      if (cnt_clr || state == IDLE || state == BREAK) cnt <= '0;
      else                                            cnt <= cnt + CNT_W'(1);
      if (state != DATA)  bit_idx <= 3'd0;
      else if (shift_en)  bit_idx <= bit_idx + 3'd1;
    end
  end

  // LSB-first data shift register (pure datapath, no reset)
  always_ff @(posedge clk) begin
    if (shift_en) shift_reg <= {rx_s, shift_reg[7:1]};
  end

  // Received byte register and frame status pulses
  always_ff @(posedge clk) begin
    if (!rst) begin
      rxByte   <= 8'h00;
      rxValid  <= 1'b0;
      frameErr <= 1'b0;
    end else begin
      rxValid  <= byte_ok;
      frameErr <= frame_bad;
      if (byte_ok) rxByte <= shift_reg;
    end
  end

  // Command decoder: acts on the rxValid cycle, results appear one cycle later
  always_ff @(posedge clk) begin
    if (!rst) begin
      cmdDir      <= DC_STOP;
      cmdDrive    <= FORWARDS;
      cmdOverride <= 1'b0;
      cmdValid    <= 1'b0;
      cmdErr      <= 1'b0;
    end else begin
      cmdValid <= 1'b0;
      cmdErr   <= 1'b0;
      if (rxValid) begin
        case (fold_case(rxByte))
          8'h50: begin cmdDir <= DC_PROCEED;    cmdValid <= 1'b1; end
          8'h4C: begin cmdDir <= DC_TURN_LEFT;  cmdValid <= 1'b1; end
          8'h52: begin cmdDir <= DC_TURN_RIGHT; cmdValid <= 1'b1; end
          8'h53: begin cmdDir <= DC_STOP;       cmdValid <= 1'b1; end
          8'h46: begin cmdDrive <= FORWARDS;    cmdValid <= 1'b1; end
          8'h42: begin cmdDrive <= REVERSE;     cmdValid <= 1'b1; end
          8'h4D: begin cmdOverride <= 1'b1;     cmdValid <= 1'b1; end
          8'h41: begin
            cmdOverride <= 1'b0;
            cmdDir      <= DC_STOP;
            cmdValid    <= 1'b1;
          end
          8'h0D, 8'h0A: begin end
          default: cmdErr <= 1'b1;
        endcase
      end
    end
  end

endmodule
